// File: rtl/gpr_seq_pkg.sv
// Shared opcodes, FSM state encoding and per-opcode step counts for the GPR transfer sequencer.
package gpr_seq_pkg;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    // The encoding doubles as the step number, so S<k> == k.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } state_e;

    function automatic logic [1:0] step_count(input logic [1:0] op);
        return ((op == OP_MOV) || (op == OP_LDI)) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/gpr_xfer_seq_idx2onehot.sv
// Register-index to one-hot decoder with enable; out-of-range indices give all zeros.
module idx2onehot
    import gpr_seq_pkg::*;
#(
    parameter int IDX_W    = 2,
    parameter int NUM_REGS = 4
) (
    input  logic                en_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Compare against every legal index so that unused codes never set a bit.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && (32'(idx_i) == 32'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_xfer_seq.sv
// Register-transfer micro-sequencer: expands one command into 1-3 registered strobe steps.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  ST_IDLE | waiting for a command, cmd_ready high
//  ST_S1   | first step strobes driven (last step for MOV/LDI)
//  ST_S2   | second step strobes driven (ALU/SWAP)
//  ST_S3   | third and final step strobes driven (ALU/SWAP)
module gpr_xfer_seq
    import gpr_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [IDX_W-1:0]    cmd_rd,
    input  logic [IDX_W-1:0]    cmd_rs,
    input  logic [2:0]          cmd_alu,
    output logic [NUM_REGS-1:0] s_r,
    output logic [NUM_REGS-1:0] e_r,
    output logic                s_tmp,
    output logic                e_tmp,
    output logic                s_acc,
    output logic                e_acc,
    output logic                e_ext,
    output logic [2:0]          alu_fn,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic [IDX_W-1:0]    rs_q, rs_d;
    logic [2:0]          alu_fn_q, alu_fn_d;

    logic                accept;
    logic                set_en, en_en;
    logic [IDX_W-1:0]    set_idx, en_idx;
    logic [NUM_REGS-1:0] s_r_d, e_r_d;
    logic                s_tmp_d, e_tmp_d, s_acc_d, e_acc_d, e_ext_d;
    logic                busy_d, done_d;

    logic [NUM_REGS-1:0] s_r_q, e_r_q;
    logic                s_tmp_q, e_tmp_q, s_acc_q, e_acc_q, e_ext_q;
    logic                busy_q, done_q;

    assign accept = cmd_valid && (state_q == ST_IDLE);

    // Next state and command latch; on accept the *_d values already carry the new command.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        alu_fn_d = alu_fn_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_S1;
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rs_d    = cmd_rs;
                    if (cmd_op == OP_ALU) begin
                        alu_fn_d = cmd_alu;
                    end
                end
            end
            ST_S1:   state_d = (step_count(op_q) == 2'd1) ? ST_IDLE : ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes for the step about to be entered, so they appear registered in that step's cycle.
    always_comb begin
        set_en  = 1'b0;
        set_idx = rd_d;
        en_en   = 1'b0;
        en_idx  = rs_d;
        s_tmp_d = 1'b0;
        e_tmp_d = 1'b0;
        s_acc_d = 1'b0;
        e_acc_d = 1'b0;
        e_ext_d = 1'b0;
        case (state_d)
            ST_S1: begin
                case (op_d)
                    OP_MOV: begin
                        en_en  = 1'b1;
                        set_en = 1'b1;
                    end
                    OP_LDI: begin
                        e_ext_d = 1'b1;
                        set_en  = 1'b1;
                    end
                    OP_ALU: begin
                        en_en   = 1'b1;
                        s_tmp_d = 1'b1;
                    end
                    default: begin
                        en_en   = 1'b1;
                        en_idx  = rd_d;
                        s_tmp_d = 1'b1;
                    end
                endcase
            end
            ST_S2: begin
                if (op_d == OP_ALU) begin
                    en_en   = 1'b1;
                    en_idx  = rd_d;
                    s_acc_d = 1'b1;
                end else if (op_d == OP_SWAP) begin
                    en_en  = 1'b1;
                    set_en = 1'b1;
                end
            end
            ST_S3: begin
                if (op_d == OP_ALU) begin
                    e_acc_d = 1'b1;
                    set_en  = 1'b1;
                end else if (op_d == OP_SWAP) begin
                    e_tmp_d = 1'b1;
                    set_en  = 1'b1;
                    set_idx = rs_d;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d != ST_IDLE) && (2'(state_d) == step_count(op_d));
    end

    idx2onehot #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_set_dec (
        .en_i     (set_en),
        .idx_i    (set_idx),
        .onehot_o (s_r_d)
    );

    idx2onehot #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_en_dec (
        .en_i     (en_en),
        .idx_i    (en_idx),
        .onehot_o (e_r_d)
    );

    // State, command latch and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MOV;
            rd_q     <= '0;
            rs_q     <= '0;
            alu_fn_q <= '0;
            s_r_q    <= '0;
            e_r_q    <= '0;
            s_tmp_q  <= 1'b0;
            e_tmp_q  <= 1'b0;
            s_acc_q  <= 1'b0;
            e_acc_q  <= 1'b0;
            e_ext_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            alu_fn_q <= alu_fn_d;
            s_r_q    <= s_r_d;
            e_r_q    <= e_r_d;
            s_tmp_q  <= s_tmp_d;
            e_tmp_q  <= e_tmp_d;
            s_acc_q  <= s_acc_d;
            e_acc_q  <= e_acc_d;
            e_ext_q  <= e_ext_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign s_r       = s_r_q;
    assign e_r       = e_r_q;
    assign s_tmp     = s_tmp_q;
    assign e_tmp     = e_tmp_q;
    assign s_acc     = s_acc_q;
    assign e_acc     = e_acc_q;
    assign e_ext     = e_ext_q;
    assign alu_fn    = alu_fn_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gpr_xfer_seq.sv
// Testbench for gpr_xfer_seq: directed table, hand-written corner sequences and a random run
// against a step-list reference model.
module tb_gpr_xfer_seq;

    logic       clk = 1'b0;
    logic       reset_n, cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_rs;
    logic [2:0] cmd_alu, alu_fn;
    logic [3:0] s_r, e_r;
    logic       s_tmp, e_tmp, s_acc, e_acc, e_ext, busy, done;

    gpr_xfer_seq #(.NUM_REGS(4), .IDX_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_alu(cmd_alu),
        .s_r(s_r), .e_r(e_r), .s_tmp(s_tmp), .e_tmp(e_tmp), .s_acc(s_acc), .e_acc(e_acc),
        .e_ext(e_ext), .alu_fn(alu_fn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s_r;
        logic [3:0] e_r;
        logic s_tmp, e_tmp, s_acc, e_acc, e_ext;
    } step_t;

    typedef struct packed {
        logic [1:0] op, rd, rs;
        logic [2:0] fn;
        logic [1:0] n;
        step_t st0, st1, st2;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [7:0] regs [4];
    logic [7:0] old_regs [4];
    logic [7:0] tmp_m, acc_m;
    localparam logic [7:0] EXT_VAL = 8'hEE;

    step_t mq[$];
    step_t cur;
    bit    have_cur;
    logic [2:0] m_fn;

    vec_t tbl [8];

    function automatic step_t mk(input logic [3:0] sr, input logic [3:0] er, input logic st,
                                 input logic et, input logic sa, input logic ea, input logic ex);
        step_t t;
        t = '{s_r: sr, e_r: er, s_tmp: st, e_tmp: et, s_acc: sa, e_acc: ea, e_ext: ex};
        return t;
    endfunction

    function automatic step_t dut_outs();
        step_t t;
        t = '{s_r: s_r, e_r: e_r, s_tmp: s_tmp, e_tmp: e_tmp, s_acc: s_acc, e_acc: e_acc, e_ext: e_ext};
        return t;
    endfunction

    function automatic step_t pick(input vec_t v, input int k);
        if (k == 0) return v.st0;
        if (k == 1) return v.st1;
        return v.st2;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-file model driven by the strobes the DUT shows in the current cycle.
    task automatic apply_bus();
        logic [7:0] bus;
        bus = 8'h00;
        for (int i = 0; i < 4; i++) if (e_r[i] === 1'b1) bus = regs[i];
        if (e_tmp === 1'b1) bus = tmp_m;
        if (e_acc === 1'b1) bus = acc_m;
        if (e_ext === 1'b1) bus = EXT_VAL;
        if (s_acc === 1'b1) acc_m = tmp_m + bus;
        for (int i = 0; i < 4; i++) if (s_r[i] === 1'b1) regs[i] = bus;
        if (s_tmp === 1'b1) tmp_m = bus;
    endtask

    task automatic tick();
        apply_bus();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk(name, 32'(cmd_ready), 32'd1);
    endtask

    // Reference: each command is a list of steps derived from the transfer rules.
    function automatic void expand(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs);
        mq.delete();
        case (op)
            2'b00: mq.push_back(mk(oh(rd), oh(rs), 0, 0, 0, 0, 0));
            2'b01: mq.push_back(mk(oh(rd), 4'b0, 0, 0, 0, 0, 1));
            2'b10: begin
                mq.push_back(mk(4'b0, oh(rs), 1, 0, 0, 0, 0));
                mq.push_back(mk(4'b0, oh(rd), 0, 0, 1, 0, 0));
                mq.push_back(mk(oh(rd), 4'b0, 0, 0, 0, 1, 0));
            end
            default: begin
                mq.push_back(mk(4'b0, oh(rd), 1, 0, 0, 0, 0));
                mq.push_back(mk(oh(rd), oh(rs), 0, 0, 0, 0, 0));
                mq.push_back(mk(oh(rs), 4'b0, 0, 1, 0, 0, 0));
            end
        endcase
    endfunction

    function automatic void model_edge(input logic rn, input logic v, input logic [1:0] op,
                                       input logic [1:0] rd, input logic [1:0] rs, input logic [2:0] fn);
        if (!rn) begin
            mq.delete();
            have_cur = 1'b0;
            m_fn     = 3'd0;
        end else if (!have_cur) begin
            if (v) begin
                expand(op, rd, rs);
                cur      = mq.pop_front();
                have_cur = 1'b1;
                if (op == 2'b10) m_fn = fn;
            end
        end else if (mq.size() == 0) begin
            have_cur = 1'b0;
        end else begin
            cur = mq.pop_front();
        end
    endfunction

    logic [3:0] drivers;
    assign drivers = {|e_r, e_tmp, e_acc, e_ext};

    always @(negedge clk) begin
        if (armed) begin
            assert ($onehot0(s_r) && $onehot0(e_r)) else begin
                errors++;
                $display("FAIL onehot: s_r=%b e_r=%b", s_r, e_r);
            end
            assert (busy ? $onehot(drivers) : (drivers == 4'b0)) else begin
                errors++;
                $display("FAIL bus_drivers: drivers=%b busy=%b", drivers, busy);
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [18:0] exp_v;
        logic        r_rn, r_v;
        logic [1:0]  r_op, r_rd, r_rs;
        logic [2:0]  r_fn;

        tbl[0] = '{op: 2'b00, rd: 2'd2, rs: 2'd1, fn: 3'd0, n: 2'd1,
                   st0: mk(4'b0100, 4'b0010, 0, 0, 0, 0, 0), st1: '0, st2: '0};
        tbl[1] = '{op: 2'b01, rd: 2'd3, rs: 2'd0, fn: 3'd0, n: 2'd1,
                   st0: mk(4'b1000, 4'b0000, 0, 0, 0, 0, 1), st1: '0, st2: '0};
        tbl[2] = '{op: 2'b10, rd: 2'd3, rs: 2'd0, fn: 3'd5, n: 2'd3,
                   st0: mk(4'b0000, 4'b0001, 1, 0, 0, 0, 0),
                   st1: mk(4'b0000, 4'b1000, 0, 0, 1, 0, 0),
                   st2: mk(4'b1000, 4'b0000, 0, 0, 0, 1, 0)};
        tbl[3] = '{op: 2'b11, rd: 2'd1, rs: 2'd2, fn: 3'd0, n: 2'd3,
                   st0: mk(4'b0000, 4'b0010, 1, 0, 0, 0, 0),
                   st1: mk(4'b0010, 4'b0100, 0, 0, 0, 0, 0),
                   st2: mk(4'b0100, 4'b0000, 0, 1, 0, 0, 0)};
        tbl[4] = '{op: 2'b00, rd: 2'd1, rs: 2'd1, fn: 3'd0, n: 2'd1,
                   st0: mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0), st1: '0, st2: '0};
        tbl[5] = '{op: 2'b10, rd: 2'd2, rs: 2'd2, fn: 3'd3, n: 2'd3,
                   st0: mk(4'b0000, 4'b0100, 1, 0, 0, 0, 0),
                   st1: mk(4'b0000, 4'b0100, 0, 0, 1, 0, 0),
                   st2: mk(4'b0100, 4'b0000, 0, 0, 0, 1, 0)};
        tbl[6] = '{op: 2'b11, rd: 2'd0, rs: 2'd0, fn: 3'd0, n: 2'd3,
                   st0: mk(4'b0000, 4'b0001, 1, 0, 0, 0, 0),
                   st1: mk(4'b0001, 4'b0001, 0, 0, 0, 0, 0),
                   st2: mk(4'b0001, 4'b0000, 0, 1, 0, 0, 0)};
        tbl[7] = '{op: 2'b01, rd: 2'd0, rs: 2'd3, fn: 3'd7, n: 2'd1,
                   st0: mk(4'b0001, 4'b0000, 0, 0, 0, 0, 1), st1: '0, st2: '0};

        regs[0] = 8'h10; regs[1] = 8'h21; regs[2] = 8'h32; regs[3] = 8'h43;
        tmp_m = 8'h00; acc_m = 8'h00;

        reset_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_rd = 2'd0; cmd_rs = 2'd0; cmd_alu = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        armed = 1'b1;
        chk("reset_outs",  32'(dut_outs()), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_done",  32'(done), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_alufn", 32'(alu_fn), 32'd0);

        for (int v = 0; v < 8; v++) begin
            wait_ready($sformatf("v%0d_ready", v));
            for (int i = 0; i < 4; i++) old_regs[i] = regs[i];
            cmd_valid = 1'b1;
            cmd_op = tbl[v].op; cmd_rd = tbl[v].rd; cmd_rs = tbl[v].rs; cmd_alu = tbl[v].fn;
            tick();
            cmd_valid = 1'b0;
            for (int k = 0; k < int'(tbl[v].n); k++) begin
                chk($sformatf("v%0d_step%0d", v, k), 32'(dut_outs()), 32'(pick(tbl[v], k)));
                chk($sformatf("v%0d_busy%0d", v, k), 32'(busy), 32'd1);
                chk($sformatf("v%0d_done%0d", v, k), 32'(done), 32'(k == int'(tbl[v].n) - 1));
                chk($sformatf("v%0d_nready%0d", v, k), 32'(cmd_ready), 32'd0);
                tick();
            end
            chk($sformatf("v%0d_gap_ready", v), 32'(cmd_ready), 32'd1);
            chk($sformatf("v%0d_gap_busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_gap_outs", v), 32'(dut_outs()), 32'd0);
            case (tbl[v].op)
                2'b00: chk($sformatf("v%0d_mov_reg", v), 32'(regs[tbl[v].rd]), 32'(old_regs[tbl[v].rs]));
                2'b01: chk($sformatf("v%0d_ldi_reg", v), 32'(regs[tbl[v].rd]), 32'(EXT_VAL));
                2'b10: begin
                    chk($sformatf("v%0d_alu_reg", v), 32'(regs[tbl[v].rd]),
                        32'(8'(old_regs[tbl[v].rs] + old_regs[tbl[v].rd])));
                    chk($sformatf("v%0d_alu_fn", v), 32'(alu_fn), 32'(tbl[v].fn));
                end
                default: begin
                    chk($sformatf("v%0d_swap_a", v), 32'(regs[tbl[v].rd]), 32'(old_regs[tbl[v].rs]));
                    chk($sformatf("v%0d_swap_b", v), 32'(regs[tbl[v].rs]), 32'(old_regs[tbl[v].rd]));
                end
            endcase
        end

        // cmd_valid held high through an ALU command: one accept, next taken after the gap cycle.
        wait_ready("hold_ready");
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rd = 2'd3; cmd_rs = 2'd0; cmd_alu = 3'd5;
        tick();
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
            if (done === 1'b1) dones++;
            tick();
        end
        chk("hold_gap_ready", 32'(cmd_ready), 32'd1);
        chk("hold_gap_busy",  32'(busy), 32'd0);
        tick();
        chk("hold_second_step1", 32'(dut_outs()), 32'(mk(4'b0000, 4'b0001, 1, 0, 0, 0, 0)));
        chk("hold_second_busy",  32'(busy), 32'd1);
        chk("hold_one_done",     32'(dones), 32'd1);
        cmd_valid = 1'b0;
        wait_ready("hold_end_ready");

        // Reset in the middle of a SWAP abandons it.
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rd = 2'd1; cmd_rs = 2'd2;
        tick();
        cmd_valid = 1'b0;
        chk("rst_swap_s1", 32'(dut_outs()), 32'(mk(4'b0000, 4'b0010, 1, 0, 0, 0, 0)));
        tick();
        chk("rst_swap_s2", 32'(dut_outs()), 32'(mk(4'b0010, 4'b0100, 0, 0, 0, 0, 0)));
        reset_n = 1'b0;
        tick();
        chk("rst_swap_outs",  32'(dut_outs()), 32'd0);
        chk("rst_swap_busy",  32'(busy), 32'd0);
        chk("rst_swap_done",  32'(done), 32'd0);
        chk("rst_swap_alufn", 32'(alu_fn), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rel_outs",  32'(dut_outs()), 32'd0);
        tick();
        chk("rst_rel_outs2", 32'(dut_outs()), 32'd0);
        chk("rst_rel_busy",  32'(busy), 32'd0);

        // Random run against the step-list model.
        mq.delete();
        have_cur = 1'b0;
        m_fn = 3'd0;
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            r_rn = ($urandom_range(63) != 0);
            r_v  = 1'($urandom_range(1));
            r_op = 2'($urandom_range(3));
            r_rd = 2'($urandom_range(3));
            r_rs = 2'($urandom_range(3));
            r_fn = 3'($urandom_range(7));
            reset_n = r_rn; cmd_valid = r_v;
            cmd_op = r_op; cmd_rd = r_rd; cmd_rs = r_rs; cmd_alu = r_fn;
            tick();
            model_edge(r_rn, r_v, r_op, r_rd, r_rs, r_fn);
            exp_v = {(have_cur ? cur : step_t'('0)), have_cur, have_cur && (mq.size() == 0), !have_cur, m_fn};
            chk($sformatf("rand%0d", c), 32'({dut_outs(), busy, done, cmd_ready, alu_fn}), 32'(exp_v));
        end

        reset_n = 1'b1;
        cmd_valid = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
